// File: rtl/fp16_lane_unpack_pkg.sv
// rtl/fp16_lane_unpack_pkg.sv - FP16 types, constants and class decode shared by the lane unpacker
// Purpose: FP16 struct typedef, FP16 constants, lane width/index types and the
//          {is_nan, is_inf, is_subnorm, is_zero} class vector decode.
// Ports:   none (package).
package fp16_lane_unpack_pkg;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] sig;
  } fp16_t;

  localparam logic [4:0] FP16_BIAS     = 5'h0F;
  localparam logic [4:0] FP16_EXP_ONES = 5'h1F;

  localparam int LANE_W = 16;

  typedef logic [1:0] lane_idx_t;

  // {is_nan, is_inf, is_subnorm, is_zero}
  typedef logic [3:0] fp16_class_t;

  function automatic fp16_class_t fp16_classify(input fp16_t h);
    fp16_class_t c;
    c = '0;
    if (h.exp == FP16_EXP_ONES) begin
      if (h.sig != '0) c[3] = 1'b1;
      else             c[2] = 1'b1;
    end else if (h.exp == 5'h00) begin
      if (h.sig != '0) c[1] = 1'b1;
      else             c[0] = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp16_lane_unpack_pick.sv
// rtl/fp16_lane_unpack_pick.sv - lowest-set-lane priority select over a lane mask
// Purpose: combinational priority pick used by fp16_lane_unpack.
// Ports:   i_mask  lanes still to emit
//          o_idx   lowest set index (0 when mask is empty)
//          o_clr   one-hot of the picked lane (0 when mask is empty)
//          o_last  no set lane remains above the picked one
module fp16_lane_pick
  import fp16_lane_unpack_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic [LANES-1:0] i_mask,
  output lane_idx_t        o_idx,
  output logic [LANES-1:0] o_clr,
  output logic             o_last
);

  logic w_found;

  always_comb begin
    w_found = 1'b0;
    o_idx   = '0;
    o_clr   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i_mask[i] && !w_found) begin
        w_found  = 1'b1;
        o_idx    = lane_idx_t'(i);
        o_clr[i] = 1'b1;
      end
    end
  end

  // Picked lane is the lowest, so anything left after clearing it lies above.
  assign o_last = ((i_mask & ~o_clr) == '0);

endmodule

// File: rtl/fp16_lane_unpack.sv
// rtl/fp16_lane_unpack.sv - serialises enabled FP16 lanes of a packed word onto a valid/ready stream
// Purpose: accepts a LANES x FP16 word with lane mask and tag, emits one enabled
//          lane per cycle (lowest first) with lane index, last flag and tag.
//          Optional macro FP16_UNPACK_CLASS_EN adds out_class.
// Ports:   clk, rst_n (async active-low)
//          in_valid/in_ready/in_data/in_mask/in_tag   input word stream
//          out_valid/out_ready/out_h/out_lane/out_last/out_tag   element stream
//          out_class (FP16_UNPACK_CLASS_EN only)  {nan, inf, subnorm, zero}
module fp16_lane_unpack
  import fp16_lane_unpack_pkg::*;
#(
  parameter int LANES = 4,
  parameter int TAGW  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [LANES-1:0]        in_mask,
  input  logic [TAGW-1:0]         in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANE_W-1:0]       out_h,
  output lane_idx_t               out_lane,
  output logic                    out_last,
  output logic [TAGW-1:0]         out_tag
`ifdef FP16_UNPACK_CLASS_EN
  ,
  output fp16_class_t             out_class
`endif
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t                  r_state, w_state_nxt;
  logic [LANES*LANE_W-1:0] r_data;
  logic [LANES-1:0]        r_rem;   // enabled lanes not yet presented
  logic [TAGW-1:0]         r_tag;
  fp16_t                   r_h;
  lane_idx_t               r_lane;
  logic                    r_last;

  logic                    w_in_fire, w_load, w_adv;
  logic [LANES*LANE_W-1:0] w_src_data;
  logic [LANES-1:0]        w_src_mask, w_pick_clr;
  lane_idx_t               w_pick_idx;
  logic                    w_pick_last;
  fp16_t                   w_pick_h;

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_EMIT) & r_last & out_ready);
  assign w_in_fire = in_valid & in_ready;

  // One picker serves both a fresh load and advancing within the held word.
  assign w_src_mask = w_load ? in_mask : r_rem;
  assign w_src_data = w_load ? in_data : r_data;

  fp16_lane_pick #(.LANES(LANES)) u_pick (
    .i_mask (w_src_mask),
    .o_idx  (w_pick_idx),
    .o_clr  (w_pick_clr),
    .o_last (w_pick_last)
  );

  assign w_pick_h = w_src_data[w_pick_idx*LANE_W +: LANE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A zero-mask word is consumed here and simply never loaded.
        if (w_in_fire && (in_mask != '0)) begin
          w_load      = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (!r_last)                               w_adv       = 1'b1;
          else if (w_in_fire && (in_mask != '0))     w_load      = 1'b1;
          else                                       w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_rem  <= '0;
      r_tag  <= '0;
      r_h    <= '0;
      r_lane <= '0;
      r_last <= 1'b0;
    end else begin
      if (w_load) begin
        r_data <= in_data;
        r_tag  <= in_tag;
      end
      if (w_load || w_adv) begin
        r_h    <= w_pick_h;
        r_lane <= w_pick_idx;
        r_last <= w_pick_last;
        r_rem  <= w_src_mask & ~w_pick_clr;
      end
    end
  end

`ifdef FP16_UNPACK_CLASS_EN
  fp16_class_t r_class;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_class <= '0;
    else if (w_load || w_adv)  r_class <= fp16_classify(w_pick_h);
  end

  assign out_class = r_class;
`endif

  assign out_valid = (r_state == S_EMIT);
  assign out_h     = r_h;
  assign out_lane  = r_lane;
  assign out_last  = r_last;
  assign out_tag   = r_tag;

endmodule

// File: tb/tb_fp16_lane_unpack.sv
// tb/tb_fp16_lane_unpack.sv - self-checking bench for fp16_lane_unpack
module tb_fp16_lane_unpack;

  localparam int TAGW = 4;

  typedef struct {
    logic [15:0] h;
    logic [1:0]  lane;
    logic        last;
    logic [3:0]  tag;
    logic [3:0]  cls;
  } elem_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     in_data;
  logic [3:0]      in_mask;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_h;
  logic [1:0]      out_lane;
  logic            out_last;
  logic [TAGW-1:0] out_tag;
  logic [3:0]      dut_class;

  int n_vec  = 0;
  int n_miss = 0;

  elem_t q[$];    // elements the block owes downstream, head = presented now
  elem_t log[$];  // elements that actually retired

  fp16_lane_unpack #(.LANES(4), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_h     (out_h),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .out_tag   (out_tag)
`ifdef FP16_UNPACK_CLASS_EN
    ,
    .out_class (dut_class)
`endif
  );

`ifndef FP16_UNPACK_CLASS_EN
  assign dut_class = 4'h0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_class(input logic [15:0] h);
    int e, f;
    e = (h >> 10) % 32;
    f = h % 1024;
    if (e == 31) return (f != 0) ? 4'b1000 : 4'b0100;
    if (e == 0)  return (f != 0) ? 4'b0010 : 4'b0001;
    return 4'b0000;
  endfunction

  // Behavioural model and per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
    end else begin
      logic exp_v, exp_rdy;
      exp_v   = (q.size() > 0);
      exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
      chk("out_valid", out_valid, exp_v);
      chk("in_ready", in_ready, exp_rdy);
      if (exp_v) begin
        chk("out_h", out_h, q[0].h);
        chk("out_lane", out_lane, q[0].lane);
        chk("out_last", out_last, q[0].last);
        chk("out_tag", out_tag, q[0].tag);
`ifdef FP16_UNPACK_CLASS_EN
        chk("out_class", dut_class, q[0].cls);
`endif
      end
      if (out_valid && out_ready) begin
        elem_t r;
        r.h = out_h; r.lane = out_lane; r.last = out_last; r.tag = out_tag; r.cls = dut_class;
        log.push_back(r);
      end
      if (exp_v && out_ready) void'(q.pop_front());
      if (in_valid && exp_rdy) begin
        for (int k = 0; k < 4; k++) begin
          if (in_mask[k]) begin
            elem_t e;
            logic [3:0] mm;
            mm     = in_mask;
            e.h    = in_data[16*k +: 16];
            e.lane = 2'(k);
            e.last = ((mm >> (k + 1)) == 4'd0);
            e.tag  = in_tag;
            e.cls  = model_class(e.h);
            q.push_back(e);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the word is taken.
  task automatic send(input logic [63:0] d, input logic [3:0] m, input logic [TAGW-1:0] t);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_mask = m; in_tag = t;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    chk("send_accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_mask  = 4'($urandom);
    in_tag   = TAGW'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin n++; @(posedge clk); end
    chk("drain_done", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_log(input int i, input logic [15:0] h, input logic [1:0] lane,
                         input logic last, input logic [3:0] tag);
    if (i >= log.size()) begin
      n_vec++; n_miss++;
      $display("FAIL log_missing: entry %0d absent, have %0d", i, log.size());
    end else begin
      chk("log_h", log[i].h, h);
      chk("log_lane", log[i].lane, lane);
      chk("log_last", log[i].last, last);
      chk("log_tag", log[i].tag, tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mask = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_h", out_h, 16'h0);
    chk("reset_out_lane", out_lane, 2'd0);
    chk("reset_out_last", out_last, 1'b0);
    chk("reset_out_tag", out_tag, 4'h0);
    chk("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // All four lanes, free-running downstream
    out_ready = 1'b1; log.delete();
    send(64'h7C00_3C00_C000_0001, 4'hF, 4'd3);
    drain();
    chk("t1_count", log.size(), 4);
    chk_log(0, 16'h0001, 2'd0, 1'b0, 4'd3);
    chk_log(1, 16'hC000, 2'd1, 1'b0, 4'd3);
    chk_log(2, 16'h3C00, 2'd2, 1'b0, 4'd3);
    chk_log(3, 16'h7C00, 2'd3, 1'b1, 4'd3);

    // Sparse mask with a stalled downstream
    out_ready = 1'b0; log.delete();
    send(64'h4444_3333_2222_1111, 4'b1010, 4'd5);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    chk("t2_count", log.size(), 2);
    chk_log(0, 16'h2222, 2'd1, 1'b0, 4'd5);
    chk_log(1, 16'h4444, 2'd3, 1'b1, 4'd5);

    // Back-to-back single-lane words
    log.delete();
    send(64'h0000_0000_0000_ABCD, 4'h1, 4'd6);
    send(64'h1234_0000_0000_0000, 4'h8, 4'd7);
    drain();
    chk("t3_count", log.size(), 2);
    chk_log(0, 16'hABCD, 2'd0, 1'b1, 4'd6);
    chk_log(1, 16'h1234, 2'd3, 1'b1, 4'd7);

    // Empty-mask word dropped, then a single-lane word
    log.delete();
    send(64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 4'd8);
    send(64'h0000_0000_BEEF_0000, 4'h2, 4'd9);
    drain();
    chk("t4_count", log.size(), 1);
    chk_log(0, 16'hBEEF, 2'd1, 1'b1, 4'd9);

    // Reset while lane 1 of a full word is pending
    out_ready = 1'b0;
    send(64'h4000_3000_2000_1000, 4'hF, 4'd10);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk); #3 rst_n = 1'b0;
    #1;
    chk("t5_async_out_valid", out_valid, 1'b0);
    log.delete();
    @(negedge clk); #3 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_residual", log.size(), 0);
    chk("t5_in_ready", in_ready, 1'b1);

`ifdef FP16_UNPACK_CLASS_EN
    log.delete();
    send(64'h7E00_7C00_0001_0000, 4'hF, 4'd1);
    drain();
    chk("t6_count", log.size(), 4);
    if (log.size() == 4) begin
      chk("t6_cls0", log[0].cls, 4'b0001);
      chk("t6_cls1", log[1].cls, 4'b0010);
      chk("t6_cls2", log[2].cls, 4'b0100);
      chk("t6_cls3", log[3].cls, 4'b1000);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
